// File: rtl/set_assoc_cache.sv
// ----------------------------------------------------------------------------
// set_assoc_cache
//   N-way set-associative, write-back / write-allocate cache with true-LRU
//   replacement, sitting between a CPU word port and a block-wide memory.
//
//   Compile-time option: define PERF_CNT_EN to build the 16-bit saturating
//   hit/miss counters. Without it, hit_count/miss_count are tied to zero.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   request, accepted only in IDLE
//   cpu_ready/hit/rdata     one-cycle completion pulse with hit flag and data
//   mem_req/we/addr/wdata   block request, held until mem_ack
//   mem_rdata, mem_ack      fill block and one-cycle acknowledge
//   hit_count, miss_count   performance counters (optional)
// ----------------------------------------------------------------------------
module set_assoc_cache #(
    parameter int ADDR_W = 10,
    parameter int WAYS   = 2,
    parameter int SETS   = 2,
    parameter int WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    output logic [31:0]           cpu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [32*WORDS-1:0]   mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_ack,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int OFF_W  = 2 + $clog2(WORDS);
    localparam int IDX_W  = (SETS > 1) ? $clog2(SETS) : 0;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int SET_W  = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W = $clog2(WORDS);
    localparam int LINE_W = 32 * WORDS;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, RESPOND} state_t;

    state_t state, state_next;

    // Captured request
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [WAY_W-1:0]  vic_way;

    // Line state
    logic              valid    [SETS][WAYS];
    logic              dirty    [SETS][WAYS];
    logic [WAY_W-1:0]  age      [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] data_mem [SETS][WAYS];

    // Address decode of the captured request
    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  req_set;
    logic [WORD_W-1:0] req_word;

    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_set  = SET_W'((req_addr >> OFF_W) & ADDR_W'(SETS - 1));
    assign req_word = WORD_W'(req_addr >> 2);

    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] t,
                                                     input logic [SET_W-1:0] s);
        return (ADDR_W'(t) << (IDX_W + OFF_W)) | (ADDR_W'(s) << OFF_W);
    endfunction

    // Lookup and victim choice
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] miss_way;
    logic             victim_dirty;
    logic [WAY_W-1:0] acc_way;
    logic             do_access;
    logic [31:0]      acc_word;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        miss_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_set][w] && tag_mem[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_set][w]) begin
                inv_found = 1'b1;
                miss_way  = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[req_set][w] == WAY_W'(WAYS - 1)) miss_way = WAY_W'(w);
            end
        end
    end

    assign victim_dirty = valid[req_set][miss_way] && dirty[req_set][miss_way];
    assign acc_way      = (state == RESPOND) ? vic_way : hit_way;
    assign do_access    = (state == COMPARE && hit) || (state == RESPOND);
    assign acc_word     = data_mem[req_set][acc_way][32*req_word +: 32];

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking assignments here would create order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (cpu_req) state_next = COMPARE;
            COMPARE: begin
                if (hit)               state_next = IDLE;
                else if (victim_dirty) state_next = WRITEBACK;
                else                   state_next = FILL;
            end
            WRITEBACK: if (mem_ack) state_next = FILL;
            // The fill only completes against a raised request; an ack seen in
            // the idle gap after a write-back is ignored.
            FILL:      if (mem_req && mem_ack) state_next = RESPOND;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Control, line state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= WAY_W'(w);
                end
            end
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            vic_way   <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= 1'b1;
                        if (!req_we) cpu_rdata <= acc_word;
                        else         dirty[req_set][hit_way] <= 1'b1;
                    end else begin
                        vic_way <= miss_way;
                        mem_req <= 1'b1;
                        if (victim_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= block_addr(tag_mem[req_set][miss_way], req_set);
                            mem_wdata <= data_mem[req_set][miss_way];
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= block_addr(req_tag, req_set);
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        // Drop the request for a cycle before the fill.
                        mem_req                 <= 1'b0;
                        dirty[req_set][vic_way] <= 1'b0;
                    end
                end
                FILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= block_addr(req_tag, req_set);
                    end else if (mem_ack) begin
                        mem_req                 <= 1'b0;
                        valid[req_set][vic_way] <= 1'b1;
                        dirty[req_set][vic_way] <= 1'b0;
                    end
                end
                RESPOND: begin
                    cpu_ready <= 1'b1;
                    if (!req_we) cpu_rdata <= acc_word;
                    else         dirty[req_set][vic_way] <= 1'b1;
                end
                default: ;
            endcase

            // True LRU: accessed way becomes youngest, younger ways age by one.
            if (do_access) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == acc_way)
                        age[req_set][w] <= '0;
                    else if (age[req_set][w] < age[req_set][acc_way])
                        age[req_set][w] <= age[req_set][w] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and data arrays
    // NOTE: the tag/data arrays have no reset; valid bits gate every use, so
    // resetting them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_req && mem_ack) begin
            tag_mem[req_set][vic_way]  <= req_tag;
            data_mem[req_set][vic_way] <= mem_rdata;
        end
        if (do_access && req_we)
            data_mem[req_set][acc_way][32*req_word +: 32] <= req_wdata;
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == COMPARE && hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (state == RESPOND && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// ----------------------------------------------------------------------------
// tb_set_assoc_cache
//   Directed bench for set_assoc_cache (default parameters). Expected CPU
//   responses and memory transactions are queued when a request is issued;
//   a CPU monitor and a memory responder pop and compare them.
// ----------------------------------------------------------------------------
module tb_set_assoc_cache;

    localparam int ADDR_W = 10;
    localparam int WORDS  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cpu_req, cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [31:0]        cpu_wdata;
    logic               cpu_ready, cpu_hit;
    logic [31:0]        cpu_rdata;
    logic               mem_req, mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [32*WORDS-1:0] mem_wdata, mem_rdata;
    logic               mem_ack;
    logic [15:0]        hit_count, miss_count;

    set_assoc_cache #(.ADDR_W(ADDR_W), .WAYS(2), .SETS(2), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic hit; logic [31:0] rdata; } cpu_exp_t;
    typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [127:0] data; } mem_exp_t;

    cpu_exp_t exp_cpu[$];
    mem_exp_t exp_mem[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_hits   = 0;
    int n_miss   = 0;
    logic hold_mem = 1'b0;
    logic [31:0] mem_model [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: got %s", name, what);
    endtask

    task automatic push_mem(input logic we, input logic [ADDR_W-1:0] addr, input logic [127:0] data);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_mem.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          input logic exp_hit, input logic [31:0] exp_rd);
        cpu_exp_t e;
        bit seen;
        e.hit = exp_hit; e.rdata = exp_rd;
        exp_cpu.push_back(e);
        if (exp_hit) n_hits++; else n_miss++;
        issue(we, addr, wd);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cpu_ready) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) fail_now("cpu_ready_timeout", "no completion within 100 cycles");
    endtask

    // CPU monitor
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cpu_ready) begin
                if (exp_cpu.size() == 0) begin
                    fail_now("cpu_unexpected", "cpu_ready with nothing expected");
                end else begin
                    e = exp_cpu.pop_front();
                    check("cpu_hit", 128'(cpu_hit), 128'(e.hit));
                    check("cpu_rdata", 128'(cpu_rdata), 128'(e.rdata));
                end
            end
        end
    end

    // Memory responder: checks each new request, acks after two cycles
    initial begin
        mem_exp_t e;
        logic [127:0] blk;
        int base;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && !hold_mem) begin
                if (exp_mem.size() == 0) begin
                    fail_now("mem_unexpected", "memory request with nothing expected");
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_we", 128'(mem_we), 128'(e.we));
                    check("mem_addr", 128'(mem_addr), 128'(e.addr));
                    if (e.we) check("mem_wdata", mem_wdata, e.data);
                end
                repeat (2) @(negedge clk);
                base = int'(mem_addr) >> 2;
                if (mem_we) begin
                    for (int k = 0; k < WORDS; k++) mem_model[base + k] = mem_wdata[32*k +: 32];
                end else begin
                    for (int k = 0; k < WORDS; k++) blk[32*k +: 32] = mem_model[base + k];
                    mem_rdata = blk;
                end
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'hA000_0000 + 32'(i * 4);
        mem_model[0] = 32'h0000_0000;
        mem_model[1] = 32'h0000_0011;
        mem_model[2] = 32'h0000_0022;
        mem_model[3] = 32'h0000_0033;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 128'(cpu_ready), 128'(0));
        check("rst_cpu_hit", 128'(cpu_hit), 128'(0));
        check("rst_cpu_rdata", 128'(cpu_rdata), 128'(0));
        check("rst_mem_req", 128'(mem_req), 128'(0));
        check("rst_mem_we", 128'(mem_we), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", mem_wdata, 128'(0));
        check("rst_hit_count", 128'(hit_count), 128'(0));
        check("rst_miss_count", 128'(miss_count), 128'(0));
        rst_n = 1'b1;

        // Cold miss, fill of block 0x000
        push_mem(1'b0, 10'h000, '0);
        cpu_op(1'b0, 10'h000, '0, 1'b0, 32'h0000_0000);
        // Hits within the block
        cpu_op(1'b0, 10'h004, '0, 1'b1, 32'h0000_0011);
        cpu_op(1'b0, 10'h00C, '0, 1'b1, 32'h0000_0033);
        // Write hit: rdata keeps its previous value
        cpu_op(1'b1, 10'h008, 32'hCAFE_BABE, 1'b1, 32'h0000_0033);
        cpu_op(1'b0, 10'h008, '0, 1'b1, 32'hCAFE_BABE);
        // Miss into invalid way1
        push_mem(1'b0, 10'h020, '0);
        cpu_op(1'b0, 10'h020, '0, 1'b0, 32'hA000_0020);
        // Miss evicting dirty way0 (block 0x000)
        push_mem(1'b1, 10'h000, {32'h0000_0033, 32'hCAFE_BABE, 32'h0000_0011, 32'h0000_0000});
        push_mem(1'b0, 10'h040, '0);
        cpu_op(1'b0, 10'h040, '0, 1'b0, 32'hA000_0040);
        // Hit on 0x020, then miss evicting clean 0x040 block
        cpu_op(1'b0, 10'h020, '0, 1'b1, 32'hA000_0020);
        push_mem(1'b0, 10'h000, '0);
        cpu_op(1'b0, 10'h000, '0, 1'b0, 32'h0000_0000);
        cpu_op(1'b0, 10'h008, '0, 1'b1, 32'hCAFE_BABE);
        // Set 1
        push_mem(1'b0, 10'h010, '0);
        cpu_op(1'b0, 10'h010, '0, 1'b0, 32'hA000_0010);

        repeat (2) @(negedge clk);
        check("pre_rst_hit_count", 128'(hit_count),
`ifdef PERF_CNT_EN
              128'(n_hits));
`else
              128'(0));
`endif
        check("pre_rst_miss_count", 128'(miss_count),
`ifdef PERF_CNT_EN
              128'(n_miss));
`else
              128'(0));
`endif

        // Reset while a fill waits for its ack
        hold_mem = 1'b1;
        issue(1'b0, 10'h030, '0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) fail_now("fill_req_timeout", "no mem_req within 20 cycles");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", 128'(mem_req), 128'(0));
        check("midrst_hit_count", 128'(hit_count), 128'(0));
        check("midrst_miss_count", 128'(miss_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        hold_mem = 1'b0;
        n_hits = 0;
        n_miss = 0;
        repeat (2) @(negedge clk);
        check("post_rst_mem_req", 128'(mem_req), 128'(0));
        check("post_rst_cpu_ready", 128'(cpu_ready), 128'(0));

        // Lines were invalidated: 0x000 misses again, data shows the write-back
        push_mem(1'b0, 10'h000, '0);
        cpu_op(1'b0, 10'h000, '0, 1'b0, 32'h0000_0000);
        cpu_op(1'b0, 10'h008, '0, 1'b1, 32'hCAFE_BABE);

        repeat (4) @(negedge clk);
        check("final_hit_count", 128'(hit_count),
`ifdef PERF_CNT_EN
              128'(n_hits));
`else
              128'(0));
`endif
        check("final_miss_count", 128'(miss_count),
`ifdef PERF_CNT_EN
              128'(n_miss));
`else
              128'(0));
`endif
        check("cpu_queue_empty", 128'(exp_cpu.size()), 128'(0));
        check("mem_queue_empty", 128'(exp_mem.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
Clocked, parametrised N-way set-associative cache between the CPU datapath and a block-wide main memory. It is write-back and write-allocate, with true-LRU replacement. It replaces the earlier zero-time, delay-based 2-way cache with a synthesizable FSM and req/ack handshakes on both sides. WAYS, SETS and block size are parameters.

Parameters:
ADDR_W, 10, byte address width
WAYS, 2, associativity; power of 2, 1..8
SETS, 2, number of sets; power of 2
WORDS, 4, 32-bit words per block; power of 2, >=2
Derived: OFF_W=2+log2(WORDS), IDX_W=log2(SETS) (0 if SETS=1), TAG_W=ADDR_W-IDX_W-OFF_W
Address split: [ADDR_W-1:IDX_W+OFF_W] tag, [IDX_W+OFF_W-1:OFF_W] index, [OFF_W-1:2] word, [1:0] ignored

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request strobe
cpu_we  in  1  0 read, 1 write
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  32  write word
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  1 if the completed request hit; valid with cpu_ready
cpu_rdata  out  32  read word; valid with cpu_ready
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  0 block read, 1 block write-back
mem_addr  out  ADDR_W  block-aligned address (offset bits zero)
mem_wdata  out  32*WORDS  write-back block; word k at [32k+31:32k]
mem_rdata  in  32*WORDS  fill block; sampled on the mem_ack edge
mem_ack  in  1  one-cycle acknowledge
hit_count  out  16  hit counter (optional feature)
miss_count  out  16  miss counter (optional feature)

Behaviour:
- Per line: valid, dirty, tag, WORDS×32 data, and a log2(WAYS)-bit age.
- Reset (async, rst_n=0): all valid/dirty=0; age of way i=i; state=IDLE; cpu_ready=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0. Data and tag arrays are not reset. Reset mid-operation abandons the transaction; no partial write-back or fill is retained.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL, RESPOND.
- IDLE: cpu_req=1 at an edge captures we/addr/wdata and moves to COMPARE. cpu_req in any other state is ignored.
- COMPARE, hit (valid and tag equal in exactly one way):
  - Read: cpu_rdata=word.
  - Write: word=cpu_wdata, dirty=1; cpu_rdata holds its old value.
  - cpu_ready=1, cpu_hit=1, LRU update, then IDLE. Hit latency is one cycle after acceptance.
- COMPARE, miss: choose the victim as the lowest-index invalid way, otherwise the way with age WAYS-1.
  - Victim valid and dirty: WRITEBACK, with mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim data.
  - Otherwise: FILL.
- WRITEBACK: hold mem_* stable until mem_ack, then clear dirty and go to FILL. mem_req drops for at least one cycle between transactions.
- FILL: mem_req=1, mem_we=0, mem_addr={req tag, index, 0}. On mem_ack, write data=mem_rdata, tag, valid=1, dirty=0, then go to RESPOND.
- RESPOND: perform the read or the write-merge (dirty=1) as on a hit. cpu_ready=1, cpu_hit=0, LRU update, then IDLE.
- LRU update: accessed way age=0; every way in the set with age less than the old age increments by 1. Ages stay a permutation of 0..WAYS-1.
- cpu_ready and cpu_hit are high for exactly one cycle per accepted request.
- mem_ack received outside WRITEBACK/FILL is ignored.

Optional Feature:
PERF_CNT_EN.
- Defined: hit_count increments on each hit completion and miss_count on each miss completion. Both are 16-bit, saturate at 0xFFFF, and are cleared by reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Cold read 0x000; memory acks fill of 0x000 with words {0x33,0x22,0x11,0x00} (word0=0x00) -> mem_req read at 0x000, cpu_ready with cpu_hit=0, cpu_rdata=0x00.
- Read 0x004 then 0x00C -> one-cycle hits, cpu_hit=1, rdata 0x11 then 0x33; no mem_req.
- Write 0x008 data 0xCAFEBABE (hit), then read 0x008 -> cpu_hit=1, rdata 0xCAFEBABE; no memory traffic.
- Read 0x020 (miss, way1 fill, no write-back), then read 0x040 -> victim is way0 (block 0x000, dirty): write-back at mem_addr 0x000 with word2=0xCAFEBABE, then fill 0x040; cpu_hit=0.
- Read 0x020 -> hit. Then read 0x000 -> miss, victim is the 0x040 block (clean), no write-back.
- rst_n pulsed low while FILL is waiting for ack -> mem_req=0 immediately, state IDLE. Re-read 0x000 -> miss (valid cleared). With PERF_CNT_EN, counters read 0 after reset.
